// File: rtl/mem_port_arbiter.sv
// Two-port data-memory arbiter: pipeline port 0 has priority, loader port 1 is
// guaranteed a grant after STARVE consecutive port-0 wins while it waits.
module mem_port_arbiter #(
    parameter int WIDTH  = 32,
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic [WIDTH-1:0] p0_rdata,
    output logic             p0_ack,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             p1_ack,
    output logic             stall,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             memWrite,
    output logic             memRead,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int CW = (LAT    > 1) ? $clog2(LAT + 1)    : 1;
    localparam int SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;

    logic any_req;
    logic grant1;

    assign any_req = p0_req | p1_req;
    // Port 1 also wins when it is the only requester.
    assign grant1  = p1_req & (~p0_req | (starve_q == SW'(STARVE)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        starve_d = starve_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = grant1;
                    we_d    = grant1 ? p1_we    : p0_we;
                    addr_d  = grant1 ? p1_addr  : p0_addr;
                    wdata_d = grant1 ? p1_wdata : p0_wdata;
                    cnt_d   = CW'(LAT - 1);
                    if (grant1 || !p1_req) begin
                        starve_d = '0;
                    end else if (starve_q != SW'(STARVE)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!we_q) begin
                    if (owner_q) rdata1_d = mem_rdata;
                    else         rdata0_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            starve_q <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes decode the asynchronously reset state, so reset drops them at once.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        memWrite  = (state_q == ACCESS) &  we_q;
        memRead   = (state_q == ACCESS) & ~we_q;
        p0_ack    = (state_q == RESP)   & ~owner_q;
        p1_ack    = (state_q == RESP)   &  owner_q;
        p0_rdata  = rdata0_q;
        p1_rdata  = rdata1_q;
        stall     = p0_req & ~p0_ack;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case
// sequences, and a randomized run against a transaction-phase reference model.
module tb_mem_port_arbiter;

    localparam int W      = 32;
    localparam int LAT    = 2;
    localparam int STARVE = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         p0_req, p0_we, p1_req, p1_we;
    logic [W-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [W-1:0] p0_rdata, p1_rdata;
    logic         p0_ack, p1_ack, stall, memWrite, memRead;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

    logic         dir_mode;
    logic [W-1:0] dir_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.WIDTH(W), .LAT(LAT), .STARVE(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .memWrite(memWrite), .memRead(memRead), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] memf(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign mem_rdata = dir_mode ? dir_rdata : memf(mem_addr);

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    typedef struct {
        logic         port;
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] mdata;
        logic [W-1:0] exp_rd0;
        logic [W-1:0] exp_rd1;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        logic acc;
        @(posedge clk); #1;
        dir_rdata = v.mdata;
        if (v.port) begin
            p1_req = 1; p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata;
        end else begin
            p0_req = 1; p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata;
        end
        for (int c = 0; c <= LAT + 2; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == LAT + 2) begin p0_req = 0; p1_req = 0; end
            end
            @(negedge clk);
            acc = (c >= 1) && (c <= LAT);
            chk("vec_memRead",  memRead,  acc && !v.we);
            chk("vec_memWrite", memWrite, acc && v.we);
            if (acc) begin
                chk("vec_mem_addr",  mem_addr,  v.addr);
                chk("vec_mem_wdata", mem_wdata, v.wdata);
            end
            chk("vec_p0_ack", p0_ack, (c == LAT + 1) && !v.port);
            chk("vec_p1_ack", p1_ack, (c == LAT + 1) && v.port);
            chk("vec_stall",  stall,  !v.port && (c <= LAT));
        end
        chk("vec_p0_rdata", p0_rdata, v.exp_rd0);
        chk("vec_p1_rdata", p1_rdata, v.exp_rd1);
    endtask

    // Reference model: mt counts cycles since grant (0 idle, 1..LAT access, LAT+1 response).
    int           mt;
    int           m_starve;
    logic         m_owner, m_we;
    logic [W-1:0] m_addr, m_wdata;
    logic [W-1:0] m_rd[2];

    task automatic model_reset();
        mt = 0; m_starve = 0; m_owner = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
    endtask

    task automatic model_step();
        logic g1;
        if (mt == 0) begin
            if (p0_req || p1_req) begin
                g1 = p1_req && (!p0_req || m_starve == STARVE);
                m_owner = g1;
                m_we    = g1 ? p1_we    : p0_we;
                m_addr  = g1 ? p1_addr  : p0_addr;
                m_wdata = g1 ? p1_wdata : p0_wdata;
                if (g1 || !p1_req) m_starve = 0;
                else if (m_starve < STARVE) m_starve++;
                mt = 1;
            end
        end else if (mt <= LAT) begin
            if (mt == LAT && !m_we) m_rd[m_owner] = memf(m_addr);
            mt++;
        end else begin
            mt = 0;
        end
    endtask

    int grants[$];
    int exp_grants[6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        rst_n = 0; dir_mode = 1; dir_rdata = '0;
        idle_inputs();
        #12;
        chk("rst_memRead",  memRead,  0);
        chk("rst_memWrite", memWrite, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_p0_ack",   p0_ack,   0);
        chk("rst_p1_ack",   p1_ack,   0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        do_reset();

        vecs[0] = '{0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1, 1, 32'h20, 32'h12345678, 32'hFFFF0000, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1, 0, 32'h30, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{0, 1, 32'h40, 32'hA5A5A5A5, 32'h11111111, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{1, 0, 32'h44, 32'h0,        32'h0BADC0DE, 32'hDEADBEEF, 32'h0BADC0DE};
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // p0 request dropped in the first access cycle still completes.
        @(posedge clk); #1;
        dir_rdata = 32'h600DF00D;
        p0_req = 1; p0_we = 0; p0_addr = 32'h88;
        @(posedge clk); #1 p0_req = 0; p0_addr = 32'h99;
        for (int c = 1; c <= LAT + 1; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("drop_p0_ack", p0_ack, c == LAT + 1);
            if (c <= LAT) chk("drop_mem_addr", mem_addr, 32'h88);
        end
        chk("drop_p0_rdata", p0_rdata, 32'h600DF00D);

        // Reset pulse in the middle of a write access.
        @(posedge clk); #1;
        p0_req = 1; p0_we = 1; p0_addr = 32'h50; p0_wdata = 32'h77;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_memWrite_pre", memWrite, 1);
        #1 rst_n = 0;
        #1;
        chk("rstmid_memWrite", memWrite, 0);
        chk("rstmid_p0_rdata", p0_rdata, 0);
        chk("rstmid_p1_rdata", p1_rdata, 0);
        p0_req = 0; p0_we = 0;
        @(posedge clk); #1 rst_n = 1;
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            chk("rstmid_p0_ack", p0_ack, 0);
            chk("rstmid_memRead", memRead, 0);
        end

        // Starvation: both ports request continuously from reset.
        dir_mode = 0;
        do_reset();
        p0_req = 1; p0_we = 0; p0_addr = 32'h100;
        p1_req = 1; p1_we = 0; p1_addr = 32'h200;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            @(negedge clk);
            if (p0_ack) grants.push_back(0);
            if (p1_ack) grants.push_back(1);
        end
        chk("starve_grant_count", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("starve_grant%0d", i), grants[i], exp_grants[i]);
        chk("starve_p1_rdata", p1_rdata, memf(32'h200));
        @(posedge clk); #1 idle_inputs();

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            p0_req   = ($urandom_range(0, 9) < 6);
            p1_req   = ($urandom_range(0, 9) < 5);
            p0_we    = $urandom_range(0, 1);
            p1_we    = $urandom_range(0, 1);
            p0_addr  = $urandom_range(0, 255);
            p1_addr  = $urandom_range(0, 255);
            p0_wdata = $urandom;
            p1_wdata = $urandom;
            @(negedge clk);
            chk("rnd_memRead",  memRead,  (mt >= 1 && mt <= LAT) && !m_we);
            chk("rnd_memWrite", memWrite, (mt >= 1 && mt <= LAT) && m_we);
            if (mt >= 1 && mt <= LAT) begin
                chk("rnd_mem_addr",  mem_addr,  m_addr);
                chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            chk("rnd_p0_ack",   p0_ack,   (mt == LAT + 1) && !m_owner);
            chk("rnd_p1_ack",   p1_ack,   (mt == LAT + 1) && m_owner);
            chk("rnd_stall",    stall,    p0_req && !((mt == LAT + 1) && !m_owner));
            chk("rnd_p0_rdata", p0_rdata, m_rd[0]);
            chk("rnd_p1_rdata", p1_rdata, m_rd[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
